pipeline_hazard_unit: RTL and testbench

- Parametrised hazard/forwarding controller for the 5-stage pipelined RISC-V core.
- Replaces the core's fixed forwarding logic. Adds load-use stalling, taken-branch flushing and hazard performance counters.
- Keeps an internal shadow pipeline of per-instruction register metadata from EX onward. From it, produces forwarding selects for the EX operands, a stall signal for PC and IF/ID, and per-register flush strobes.

---
 rtl/pipeline_hazard_unit.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - load-use stall, EX operand forwarding and branch flush control
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_DEPTH   = 3,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic                             CLEAR,
  input  logic                             id_valid,
  input  logic [REG_ADDR_W-1:0]            id_rs1,
  input  logic [REG_ADDR_W-1:0]            id_rs2,
  input  logic                             id_use_rs1,
  input  logic                             id_use_rs2,
  input  logic [REG_ADDR_W-1:0]            id_rd,
  input  logic                             id_reg_write,
  input  logic                             id_mem_read,
  input  logic                             branch_taken,
  output logic                             stall,
  output logic [FLUSH_DEPTH-1:0]           flush,
  output logic [$clog2(FWD_DEPTH+1)-1:0]   fwd_sel_a,
  output logic [$clog2(FWD_DEPTH+1)-1:0]   fwd_sel_b,
  output logic [CNT_W-1:0]                 stall_cnt,
  output logic [CNT_W-1:0]                 flush_cnt
);

  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  // Shadow pipeline: slot 0 is EX, slot k is k stages downstream of EX.
  // Only the EX consumer needs its source fields, so those live in slot 0 alone.
  logic                  s_valid     [0:FWD_DEPTH];
  logic                  s_reg_write [0:FWD_DEPTH];
  logic                  s_is_load   [0:FWD_DEPTH];
  logic [REG_ADDR_W-1:0] s_rd        [0:FWD_DEPTH];
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic                  ex_use_rs1;
  logic                  ex_use_rs2;

  logic                  load_hazard;
  logic [SEL_W-1:0]      sel_a;
  logic [SEL_W-1:0]      sel_b;

  // Advance the shadow pipeline; a taken branch squashes the younger slots.
  always_ff @(posedge CLK) begin
    if (!RESET_N || CLEAR) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        s_valid[k]     <= 1'b0;
        s_reg_write[k] <= 1'b0;
        s_is_load[k]   <= 1'b0;
        s_rd[k]        <= '0;
      end
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_use_rs1 <= 1'b0;
      ex_use_rs2 <= 1'b0;
    end else begin
      s_valid[0]     <= id_valid && !stall && !branch_taken;
      s_reg_write[0] <= id_reg_write;
      s_is_load[0]   <= id_mem_read;
      s_rd[0]        <= id_rd;
      ex_rs1         <= id_rs1;
      ex_rs2         <= id_rs2;
      ex_use_rs1     <= id_use_rs1;
      ex_use_rs2     <= id_use_rs2;
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        s_valid[k]     <= (branch_taken && (k <= FLUSH_DEPTH - 2)) ? 1'b0 : s_valid[k-1];
        s_reg_write[k] <= s_reg_write[k-1];
        s_is_load[k]   <= s_is_load[k-1];
        s_rd[k]        <= s_rd[k-1];
      end
    end
  end

  // Pick the youngest eligible producer per operand; scanning oldest-first lets the youngest overwrite.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (s_valid[k] && s_reg_write[k] && (s_rd[k] != '0) &&
          !(s_is_load[k] && (k < 1 + LOAD_LAT))) begin
        if (s_valid[0] && ex_use_rs1 && (s_rd[k] == ex_rs1)) sel_a = SEL_W'(k);
        if (s_valid[0] && ex_use_rs2 && (s_rd[k] == ex_rs2)) sel_b = SEL_W'(k);
      end
    end
  end

  // Detect an ID source that depends on a load whose data is not yet forwardable.
  always_comb begin
    load_hazard = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (s_valid[k] && s_is_load[k] && (s_rd[k] != '0)) begin
        if (id_use_rs1 && (id_rs1 == s_rd[k])) load_hazard = 1'b1;
        if (id_use_rs2 && (id_rs2 == s_rd[k])) load_hazard = 1'b1;
      end
    end
  end

  // A taken branch squashes the ID instruction, so it overrides any stall.
  assign stall     = id_valid && load_hazard && !branch_taken;
  assign flush     = {FLUSH_DEPTH{branch_taken}};
  assign fwd_sel_a = sel_a;
  assign fwd_sel_b = sel_b;

  // Saturating hazard event counters; CLEAR leaves them alone.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}}))        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_taken && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - directed vector bench for pipeline_hazard_unit
module tb_pipeline_hazard_unit;

  logic       CLK;
  logic       RESET_N;
  logic       CLEAR;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic       branch_taken;

  logic        stall;
  logic [2:0]  flush;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [31:0] stall_cnt, flush_cnt;

  logic        stall2;
  logic [2:0]  flush2;
  logic [1:0]  fwd_sel_a2, fwd_sel_b2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int pass_cnt = 0;
  int total_cnt = 0;

  pipeline_hazard_unit dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken),
    .stall(stall), .flush(flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_unit #(.LOAD_LAT(2), .CNT_W(2)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken),
    .stall(stall2), .flush(flush2), .fwd_sel_a(fwd_sel_a2), .fwd_sel_b(fwd_sel_b2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       vld;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr, br;
    logic       e_stall;
    logic [2:0] e_flush;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(logic vld, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic rw, logic mr, logic br,
                              logic es, logic [2:0] ef, logic [1:0] efa, logic [1:0] efb);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.mr = mr; v.br = br;
    v.e_stall = es; v.e_flush = ef; v.e_fa = efa; v.e_fb = efb;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br);
    id_valid = vld; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; branch_taken = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0; CLEAR = 1'b0; idle();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0; CLEAR = 1'b0; idle();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_fa", fwd_sel_a, 0);
    chk("rst_fb", fwd_sel_b, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);

    //            vld rs1 rs2 u1 u2 rd rw mr br  stall flush fa fb
    tbl[0]  = mk(1, 1, 2, 1, 1, 5,  1, 0, 0,  0, 3'b000, 0, 0); // add x5
    tbl[1]  = mk(1, 5, 0, 1, 0, 10, 1, 0, 0,  0, 3'b000, 0, 0); // uses x5
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 3'b000, 1, 0); // back-to-back fwd
    tbl[3]  = mk(1, 0, 0, 0, 0, 7,  1, 0, 0,  0, 3'b000, 0, 0); // producer x7
    tbl[4]  = mk(1, 0, 0, 0, 0, 11, 1, 0, 0,  0, 3'b000, 0, 0); // filler
    tbl[5]  = mk(1, 0, 7, 0, 1, 0,  0, 0, 0,  0, 3'b000, 0, 0); // rs2=7, distance 2
    tbl[6]  = mk(1, 0, 7, 0, 1, 0,  0, 0, 0,  0, 3'b000, 0, 2); // rs2=7, distance 3
    tbl[7]  = mk(1, 0, 7, 0, 1, 0,  0, 0, 0,  0, 3'b000, 0, 3); // rs2=7, distance 4
    tbl[8]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 3'b000, 0, 0); // producer gone
    tbl[9]  = mk(1, 1, 0, 1, 0, 6,  1, 1, 0,  0, 3'b000, 0, 0); // lw x6
    tbl[10] = mk(1, 6, 0, 1, 0, 13, 1, 0, 0,  1, 3'b000, 0, 0); // load-use stall
    tbl[11] = mk(1, 6, 0, 1, 0, 13, 1, 0, 0,  0, 3'b000, 0, 0); // held, released
    tbl[12] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 3'b000, 2, 0); // load fwd from WB
    tbl[13] = mk(1, 0, 0, 0, 0, 9,  1, 0, 0,  0, 3'b000, 0, 0); // x9 older
    tbl[14] = mk(1, 0, 0, 0, 0, 9,  1, 0, 0,  0, 3'b000, 0, 0); // x9 younger
    tbl[15] = mk(1, 9, 9, 1, 1, 14, 1, 0, 0,  0, 3'b000, 0, 0); // uses x9 twice
    tbl[16] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 3'b000, 1, 1); // youngest wins
    tbl[17] = mk(1, 0, 0, 0, 0, 0,  1, 0, 0,  0, 3'b000, 0, 0); // writes x0
    tbl[18] = mk(1, 0, 0, 1, 1, 15, 1, 0, 0,  0, 3'b000, 0, 0); // reads x0
    tbl[19] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 3'b000, 0, 0); // x0 not forwarded
    tbl[20] = mk(1, 0, 0, 0, 0, 0,  1, 1, 0,  0, 3'b000, 0, 0); // lw x0
    tbl[21] = mk(1, 0, 0, 1, 0, 16, 1, 0, 0,  0, 3'b000, 0, 0); // x0 no stall
    tbl[22] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 3'b000, 0, 0);
    tbl[23] = mk(1, 0, 0, 0, 0, 8,  1, 1, 0,  0, 3'b000, 0, 0); // lw x8
    tbl[24] = mk(1, 8, 0, 1, 0, 17, 1, 0, 1,  0, 3'b111, 0, 0); // hazard + branch
    tbl[25] = mk(1, 8, 0, 1, 0, 0,  0, 0, 0,  0, 3'b000, 0, 0); // slots 0..1 empty
    tbl[26] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 3'b000, 0, 0); // squashed lw not used

    for (int i = 0; i < 27; i++) begin
      @(negedge CLK);
      drive(tbl[i].vld, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
            tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].br);
      #1;
      chk($sformatf("v%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("v%0d_flush", i), flush, tbl[i].e_flush);
      chk($sformatf("v%0d_fa", i), fwd_sel_a, tbl[i].e_fa);
      chk($sformatf("v%0d_fb", i), fwd_sel_b, tbl[i].e_fb);
    end
    @(negedge CLK); idle(); #1;
    chk("tbl_stall_cnt", stall_cnt, 1);
    chk("tbl_flush_cnt", flush_cnt, 1);

    // LOAD_LAT=2 instance: two stall cycles, then forwarding from slot 3
    do_reset();
    drive(1, 1, 0, 1, 0, 6, 1, 1, 0);
    @(negedge CLK); drive(1, 6, 0, 1, 0, 13, 1, 0, 0); #1;
    chk("ll2_stall_c1", stall2, 1);
    @(negedge CLK); #1;
    chk("ll2_stall_c2", stall2, 1);
    @(negedge CLK); #1;
    chk("ll2_stall_c3", stall2, 0);
    @(negedge CLK); idle(); #1;
    chk("ll2_fa", fwd_sel_a2, 3);
    chk("ll2_stall_cnt", stall_cnt2, 2);

    // CLEAR during a stall: stall drops, counters survive
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge CLK); drive(1, 1, 0, 1, 0, 6, 1, 1, 0);
    @(negedge CLK); drive(1, 6, 0, 1, 0, 13, 1, 0, 0); CLEAR = 1'b1; #1;
    chk("clr_stall_before", stall2, 1);
    @(negedge CLK); CLEAR = 1'b0; #1;
    chk("clr_stall_after", stall2, 0);
    chk("clr_flush_cnt", flush_cnt2, 1);
    chk("clr_stall_cnt_le1", (stall_cnt2 <= 2'd1), 1);
    chk("clr_dut1_flush_cnt", flush_cnt, 1);

    // RESET_N with CLEAR during a stall: reset wins, counters zeroed
    @(negedge CLK); drive(1, 1, 0, 1, 0, 6, 1, 1, 0);
    @(negedge CLK); drive(1, 6, 0, 1, 0, 13, 1, 0, 0); #1;
    chk("rst2_stall_before", stall, 1);
    RESET_N = 1'b0; CLEAR = 1'b1;
    @(negedge CLK); RESET_N = 1'b1; CLEAR = 1'b0; #1;
    chk("rst2_stall_after", stall, 0);
    chk("rst2_stall_cnt", stall_cnt, 0);
    chk("rst2_flush_cnt", flush_cnt, 0);
    chk("rst2_fa", fwd_sel_a, 0);

    // Counter saturation on the narrow-counter instance
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    chk("sat_flush_out", flush2, 7);
    repeat (3) @(negedge CLK);
    @(negedge CLK); idle(); #1;
    chk("sat_flush_cnt2", flush_cnt2, 3);
    chk("sat_flush_cnt1", flush_cnt, 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
